// File: rtl/fetch_controller_if.sv
// fetch_controller_if: fetch control, instruction memory and IF/ID signals between the fetch unit and the rest of the core
interface fetch_controller_if;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        haltReq;
  logic [31:0] imemData;
  logic [31:0] imemAddr;
  logic [31:0] instrOut;
  logic [31:0] pcPlus4Out;
  logic        instrValid;
  logic        halted;
  logic [31:0] fetchCount;
  modport master (
    input  start, stall, redirect, redirectTarget, haltReq, imemData,
    output imemAddr, instrOut, pcPlus4Out, instrValid, halted, fetchCount
  );
  modport slave (
    output start, stall, redirect, redirectTarget, haltReq, imemData,
    input  imemAddr, instrOut, pcPlus4Out, instrValid, halted, fetchCount
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: IDLE/RUN/HALT instruction fetch with PC, IF/ID register and fetch counter
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input logic Clk,
  input logic Reset_n,
  fetch_controller_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [31:0] START_PC = RESET_PC & ~32'd3;
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;
  state_t      state, nextState;
  logic [31:0] pc, instrReg, pcPlus4Reg, countReg;
  logic        validReg;
  logic [31:0] seqPc, targetPc;
  logic        doFetch, doJump, doBubble, doRestart;
  assign bus.imemAddr   = pc;
  assign bus.instrOut   = instrReg;
  assign bus.pcPlus4Out = pcPlus4Reg;
  assign bus.instrValid = validReg;
  assign bus.fetchCount = countReg;
  assign bus.halted     = state == HALT;
  assign seqPc          = pc + 32'd4;
  assign targetPc       = bus.redirectTarget & ~32'd3;
  // state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else state <= nextState;
  end
  // next state and datapath controls; priority haltReq > redirect > stall > fetch, out-of-range PC halts
  always_comb begin
    nextState = state;
    doFetch   = 1'b0;
    doJump    = 1'b0;
    doBubble  = 1'b0;
    doRestart = 1'b0;
    case (state)
      IDLE: nextState = bus.start ? RUN : IDLE;
      HALT: begin
        nextState = bus.start ? RUN : HALT;
        doRestart = bus.start;
      end
      RUN: begin
        if (bus.haltReq) begin
          nextState = HALT;
          doBubble  = 1'b1;
        end else if (bus.redirect) begin
          doBubble  = 1'b1;
          doJump    = {1'b0, targetPc} < PC_LIMIT;
          nextState = doJump ? RUN : HALT;
        end else if (!bus.stall) begin
          doFetch   = {1'b0, seqPc} < PC_LIMIT;
          doBubble  = !doFetch;
          nextState = doFetch ? RUN : HALT;
        end
      end
      default: nextState = IDLE;
    endcase
  end
  // PC, IF/ID register and saturating fetch counter
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pc         <= START_PC;
      instrReg   <= '0;
      pcPlus4Reg <= '0;
      validReg   <= 1'b0;
      countReg   <= '0;
    end else begin
      if (doRestart) begin
        pc       <= START_PC;
        countReg <= '0;
      end
      if (doJump) pc <= targetPc;
      if (doFetch) begin
        pc         <= seqPc;
        instrReg   <= bus.imemData;
        pcPlus4Reg <= seqPc;
        validReg   <= 1'b1;
        countReg   <= countReg + {31'd0, ~&countReg};
      end
      if (doBubble) begin
        instrReg <= '0;
        validReg <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address fetched first after start; bits [1:0] SHALL be treated as 0.
REQ-002 Parameter IMEM_WORDS, default 1024: instruction memory depth in 32-bit words.
REQ-003 Clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-004 Reset_n  input  1: synchronous, active-low reset, sampled on rising Clk.
REQ-005 start  input  1: level; begins fetching from IDLE or HALT.
REQ-006 stall  input  1: hold PC and the IF/ID register.
REQ-007 redirect  input  1: branch/jump taken this cycle.
REQ-008 redirectTarget  input  32: new fetch byte address.
REQ-009 haltReq  input  1: decode requests stop of fetch.
REQ-010 imemData  input  32: combinational read data for imemAddr.
REQ-011 imemAddr  output  32: current PC, driven to instruction memory; always word-aligned.
REQ-012 instrOut  output  32: IF/ID instruction register.
REQ-013 pcPlus4Out  output  32: IF/ID PC+4 register.
REQ-014 instrValid  output  1: instrOut holds a real fetched instruction.
REQ-015 halted  output  1: high in HALT state.
REQ-016 fetchCount  output  32: count of instructions latched with instrValid=1.

Function
REQ-017 States SHALL be IDLE, RUN, HALT, held in a state register.
REQ-018 IDLE: PC held at RESET_PC; IF/ID holds instrOut=0, instrValid=0; start=1 -> RUN next cycle.
REQ-019 RUN, stall=0, redirect=0: instrOut<=imemData, pcPlus4Out<=PC+4, instrValid<=1, PC<=PC+4, fetchCount<=fetchCount+1.
REQ-020 Fetch latency SHALL be one cycle: instruction at address A appears on instrOut the cycle after imemAddr==A with stall=0.
REQ-021 RUN, stall=1, redirect=0: PC, instrOut, pcPlus4Out, instrValid, fetchCount SHALL hold.
REQ-022 RUN, redirect=1: PC<={redirectTarget[31:2],2'b00}; instrOut<=0, instrValid<=0 (bubble); fetchCount holds; redirect SHALL override stall.
REQ-023 RUN, haltReq=1: next state HALT; instrOut<=0, instrValid<=0; PC holds; haltReq SHALL override redirect and stall.
REQ-024 RUN, next PC (after REQ-019 or REQ-022) >= 4*IMEM_WORDS: next state HALT, PC holds its current value, instrValid<=0.
REQ-025 HALT: halted=1, instrValid=0, PC held; redirect and stall ignored; start=1 -> RUN with PC<=RESET_PC, fetchCount<=0.
REQ-026 IDLE/HALT: redirect, stall, haltReq SHALL have no effect (except start in REQ-025).
REQ-027 PC+4 SHALL wrap modulo 2^32; fetchCount SHALL saturate at 32'hFFFF_FFFF.
REQ-028 imemAddr SHALL equal the PC register; no combinational path from inputs to imemAddr.
REQ-029 start held high while in RUN SHALL have no effect.

Reset
REQ-030 Reset_n=0 at a rising edge: state<=IDLE, PC<=RESET_PC, instrOut<=0, pcPlus4Out<=0, instrValid<=0, fetchCount<=0, halted<=0.
REQ-031 Reset SHALL override all other inputs, including mid-RUN with redirect or stall asserted; outputs take reset values the cycle after the sampled edge.

Verification
REQ-032 Reset then start=1 one cycle, memory words k=0..3 hold 0x1000_000k -> imemAddr 0,4,8,C on consecutive cycles; instrOut 0x1000_0000.. one cycle later; instrValid=1; fetchCount=4.
REQ-033 RUN at PC=8, stall=1 for 3 cycles -> imemAddr stays 8, instrOut/fetchCount unchanged; after release fetch resumes at 8.
REQ-034 RUN at PC=0x10, redirect=1, target=0x43 with stall=1 -> next imemAddr=0x40, instrValid=0 one cycle, then instruction at 0x40 with pcPlus4Out=0x44.
REQ-035 IMEM_WORDS=4, run from 0 -> fetches 0..C, then halted=1, instrValid=0, imemAddr stays 0xC; start=1 -> restart at 0, fetchCount=0.
REQ-036 RUN, haltReq=1 and redirect=1 same cycle -> HALT, PC unchanged; Reset_n=0 mid-RUN with stall=1 -> IDLE, all outputs at reset values.
